// File: rtl/conv_mac_acc.sv
// ----------------------------------------------------------------------------
// conv_mac_acc
//
// Datapath stage that sits directly behind the convolution address controller.
// It takes the data / weight / bias SRAM read words that the controller has
// addressed, multiply-accumulates every beat of a window, adds the window
// bias, requantises (arithmetic shift right, floor) and saturates the result.
// It then buffers each result in a small output FIFO that feeds the
// pooling / writeback stage.
//
// Pipeline (one beat issued by the controller in cycle T):
//   T           : controller strobes cena=0 with first/last/frame_end flags
//   T+RD_LAT    : stage R - delayed flags line up with data_q/weight_q/bias_q
//   T+RD_LAT+1  : stage M - registered product and captured window bias
//   T+RD_LAT+2  : stage A - registered accumulator; on the last beat the
//                 requantised result sits in res_a and is written to the FIFO
//   T+RD_LAT+3  : result visible at the FIFO head (if the FIFO was empty)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   go                  start of frame: clears out_addr counter, overflow, done
//   cena                active-low beat strobe from the controller
//   first_data          first beat of a window (qualified by !cena)
//   last_data           last beat of a window (qualified by !cena)
//   frame_end           controller pulse: final beat of the frame issued
//   data_q, weight_q,
//   bias_q              SRAM read words, valid RD_LAT cycles after the beat
//   out_valid/out_ready output handshake
//   out_data, out_addr  FIFO head result and its index in frame order
//   overflow            sticky: a result was dropped because the FIFO was full
//   done                one-cycle pulse once the frame has fully drained
//
// Build option
//   CONV_RELU_EN : when defined, negative saturated results are replaced by 0
//                  before they are pushed, so out_data is never negative.
//
// FIFO_DEPTH must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module conv_mac_acc #(
    parameter int DATA_W     = 8,
    parameter int WEIGHT_W   = 8,
    parameter int BIAS_W     = 16,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 8,
    parameter int SHIFT      = 7,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int OADDR_W    = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       go,
    input  logic                       cena,
    input  logic                       first_data,
    input  logic                       last_data,
    input  logic                       frame_end,
    input  logic signed [DATA_W-1:0]   data_q,
    input  logic signed [WEIGHT_W-1:0] weight_q,
    input  logic signed [BIAS_W-1:0]   bias_q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    out_data,
    output logic [OADDR_W-1:0]         out_addr,
    output logic                       overflow,
    output logic                       done
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    // One guard bit above the accumulator so acc + bias never wraps.
    localparam int SUM_W  = ACC_W + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Stage R: delay the controller flags by the SRAM read latency.
    // Bit order: {frame_end, last, first, beat}.
    // ------------------------------------------------------------------
    logic [3:0] align_sr [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                align_sr[i] <= '0;
            end
        end else begin
            align_sr[0] <= {frame_end, last_data, first_data, ~cena};
            for (int i = 1; i < RD_LAT; i++) begin
                align_sr[i] <= align_sr[i-1];
            end
        end
    end

    logic beat_r;
    logic first_r;
    logic last_r;
    logic fend_r;

    assign beat_r  = align_sr[RD_LAT-1][0];
    assign first_r = align_sr[RD_LAT-1][1];
    assign last_r  = align_sr[RD_LAT-1][2];
    assign fend_r  = align_sr[RD_LAT-1][3];

    // ------------------------------------------------------------------
    // Stage M: signed product, sign-extended to the accumulator width.
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] weight_ext;
    logic signed [PROD_W-1:0] prod_full;
    logic signed [ACC_W-1:0]  prod_ext;

    assign data_ext   = {{WEIGHT_W{data_q[DATA_W-1]}}, data_q};
    assign weight_ext = {{DATA_W{weight_q[WEIGHT_W-1]}}, weight_q};
    assign prod_full  = data_ext * weight_ext;
    assign prod_ext   = {{(ACC_W-PROD_W){prod_full[PROD_W-1]}}, prod_full};

    logic                     beat_m;
    logic                     first_m;
    logic                     last_m;
    logic                     fend_m;
    logic signed [ACC_W-1:0]  prod_m;
    logic signed [BIAS_W-1:0] bias_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_m  <= 1'b0;
            first_m <= 1'b0;
            last_m  <= 1'b0;
            fend_m  <= 1'b0;
            prod_m  <= '0;
            bias_m  <= '0;
        end else begin
            beat_m  <= beat_r;
            first_m <= beat_r & first_r;
            last_m  <= beat_r & last_r;
            fend_m  <= fend_r;
            if (beat_r) begin
                prod_m <= prod_ext;
            end
            // The bias word is only meaningful on the window's first beat.
            if (beat_r && first_r) begin
                bias_m <= bias_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage A: window FSM, accumulator and requantisation.
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   win_beat;
    logic   push_next;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [SUM_W-1:0] acc_wide;
    logic signed [SUM_W-1:0] bias_wide;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] res;
    logic signed [OUT_W-1:0] sat;
    logic signed [OUT_W-1:0] res_final;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push_next  = 1'b0;
        // Beats outside a window are ignored; a first beat always (re)opens one.
        win_beat   = beat_m && (first_m || (state == S_ACC));
        if (first_m) begin
            state_next = S_ACC;
        end
        if (win_beat && last_m) begin
            push_next  = 1'b1;
            state_next = S_IDLE;
        end
        if (fend_m) begin
            state_next = S_IDLE;
        end
    end

    always_comb begin
        // A first beat discards any partial sum left from an aborted window.
        acc_base  = first_m ? '0 : acc;
        acc_next  = acc_base + prod_m;
        acc_wide  = {acc_next[ACC_W-1], acc_next};
        bias_wide = {{(SUM_W-BIAS_W){bias_m[BIAS_W-1]}}, bias_m};
        sum       = acc_wide + bias_wide;
        res       = sum >>> SHIFT;
        if (res > SAT_MAX) begin
            sat = SAT_MAX[OUT_W-1:0];
        end else if (res < SAT_MIN) begin
            sat = SAT_MIN[OUT_W-1:0];
        end else begin
            sat = res[OUT_W-1:0];
        end
        res_final = sat;
`ifdef CONV_RELU_EN
        if (sat[OUT_W-1]) begin
            res_final = '0;
        end
`endif
    end

    logic                    push_a;
    logic signed [OUT_W-1:0] res_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            push_a <= 1'b0;
            res_a  <= '0;
        end else begin
            if (win_beat) begin
                acc <= acc_next;
            end
            push_a <= push_next;
            if (push_next) begin
                res_a <= res_final;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO.
    // Handshake: the head entry is transferred on every rising edge where
    // out_valid && out_ready; while out_valid is high and out_ready low the
    // head (out_data, out_addr) holds steady. out_valid never depends on
    // out_ready.
    // ------------------------------------------------------------------
    logic signed [OUT_W-1:0] mem_data [FIFO_DEPTH];
    logic [OADDR_W-1:0]      mem_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          count;
    logic [OADDR_W-1:0]      wr_cnt;
    logic                    pop;
    logic                    full;
    logic                    wr_en;

    assign out_valid = (count != '0);
    assign out_data  = mem_data[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr_en     = push_a && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_addr[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_data[wr_ptr] <= res_a;
                mem_addr[wr_ptr] <= wr_cnt;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            // Dropped results still consume an index so downstream can see the gap.
            if (go) begin
                wr_cnt <= '0;
            end else if (push_a) begin
                wr_cnt <= wr_cnt + OADDR_W'(1);
            end
            if (go) begin
                overflow <= 1'b0;
            end else if (push_a && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame completion: once the aligned frame_end has passed stage A,
    // wait until nothing is left in res_a or the FIFO, then pulse done.
    // ------------------------------------------------------------------
    logic done_pend;
    logic done_fire;

    assign done_fire = done_pend && (count == '0) && !push_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_pend <= 1'b0;
            done      <= 1'b0;
        end else if (go) begin
            done_pend <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_fire;
            if (fend_m) begin
                done_pend <= 1'b1;
            end else if (done_fire) begin
                done_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_acc.sv
// ----------------------------------------------------------------------------
// tb_conv_mac_acc
//
// Directed bench for conv_mac_acc. Two instances share all inputs: dut uses
// SHIFT=0, dut7 uses SHIFT=7, so both requantisation paths are exercised by
// the same windows. SRAM read latency is 1: the step task presents the words
// of the previous beat on data_q/weight_q/bias_q while issuing the next beat.
// ----------------------------------------------------------------------------
module tb_conv_mac_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                go;
    logic                cena;
    logic                first_data;
    logic                last_data;
    logic                frame_end;
    logic signed [7:0]   data_q;
    logic signed [7:0]   weight_q;
    logic signed [15:0]  bias_q;
    logic                out_ready;

    logic                out_valid;
    logic signed [7:0]   out_data;
    logic [9:0]          out_addr;
    logic                overflow;
    logic                done;

    logic                out_valid7;
    logic signed [7:0]   out_data7;
    logic [9:0]          out_addr7;
    logic                overflow7;
    logic                done7;

    int pend_d = 0;
    int pend_w = 0;
    int pend_b = 0;
    int checks = 0;
    int errors = 0;

    conv_mac_acc #(.SHIFT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .cena       (cena),
        .first_data (first_data),
        .last_data  (last_data),
        .frame_end  (frame_end),
        .data_q     (data_q),
        .weight_q   (weight_q),
        .bias_q     (bias_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .overflow   (overflow),
        .done       (done)
    );

    conv_mac_acc #(.SHIFT(7)) dut7 (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .cena       (cena),
        .first_data (first_data),
        .last_data  (last_data),
        .frame_end  (frame_end),
        .data_q     (data_q),
        .weight_q   (weight_q),
        .bias_q     (bias_q),
        .out_valid  (out_valid7),
        .out_ready  (out_ready),
        .out_data   (out_data7),
        .out_addr   (out_addr7),
        .overflow   (overflow7),
        .done       (done7)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: present last beat's read words, issue this beat's strobe.
    task automatic step(input logic c_n, input logic f, input logic l,
                        input logic fe, input int d, input int w, input int b);
        data_q     = 8'(pend_d);
        weight_q   = 8'(pend_w);
        bias_q     = 16'(pend_b);
        pend_d     = d;
        pend_w     = w;
        pend_b     = b;
        cena       = c_n;
        first_data = f;
        last_data  = l;
        frame_end  = fe;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        end
    endtask

    task automatic window(input int n, input int d, input int w, input int b,
                          input logic fe);
        for (int i = 0; i < n; i++) begin
            step(1'b0, i == 0, i == n - 1, fe && (i == n - 1), d, w, b);
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        idle(1);
        go = 1'b0;
    endtask

    // Wait (bounded) for a head entry, check it on both instances, pop it.
    task automatic expect_result(input string tag, input int exp_d,
                                 input int exp_d7, input int exp_a);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            idle(1);
            n++;
        end
        check({tag, "_valid"},  32'(out_valid), 1);
        check({tag, "_data"},   out_data, exp_d);
        check({tag, "_addr"},   32'(out_addr), exp_a);
        check({tag, "_valid7"}, 32'(out_valid7), 1);
        check({tag, "_data7"},  out_data7, exp_d7);
        check({tag, "_addr7"},  32'(out_addr7), exp_a);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
    endtask

    int pulses;
    int pulses7;
    int exp_neg;
    int exp_floor;
    int exp_floor7;

    initial begin
        // ---------------- clock / reset ----------------
        rst_n      = 1'b0;
        go         = 1'b0;
        cena       = 1'b1;
        first_data = 1'b0;
        last_data  = 1'b0;
        frame_end  = 1'b0;
        data_q     = '0;
        weight_q   = '0;
        bias_q     = '0;
        out_ready  = 1'b0;
`ifdef CONV_RELU_EN
        exp_neg    = 0;
        exp_floor  = 0;
        exp_floor7 = 0;
`else
        exp_neg    = -128;
        exp_floor  = -16;
        exp_floor7 = -1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",    32'(out_valid), 0);
        check("rst_data",     out_data, 0);
        check("rst_addr",     32'(out_addr), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_done",     32'(done), 0);
        rst_n = 1'b1;
        idle(2);

        // ---------------- 1: 5x5 ones, latency, done ----------------
        pulse_go();
        window(25, 1, 1, 0, 1'b1);
        check("t1_lat_c1", 32'(out_valid), 0);
        idle(1);
        check("t1_lat_c2", 32'(out_valid), 0);
        idle(1);
        check("t1_lat_c3", 32'(out_valid), 0);
        idle(1);
        check("t1_lat_c4", 32'(out_valid), 1);
        check("t1_data",   out_data, 25);
        check("t1_addr",   32'(out_addr), 0);
        check("t1_data7",  out_data7, 0);
        idle(1);
        check("t1_hold_data", out_data, 25);
        check("t1_done_early", 32'(done), 0);
        out_ready = 1'b1;
        pulses  = 0;
        pulses7 = 0;
        for (int k = 0; k < 12; k++) begin
            idle(1);
            if (done === 1'b1) pulses++;
            if (done7 === 1'b1) pulses7++;
        end
        out_ready = 1'b0;
        check("t1_done_pulses",  pulses, 1);
        check("t1_done_pulses7", pulses7, 1);
        check("t1_drained",      32'(out_valid), 0);

        // ---------------- 2: large positive saturates ----------------
        pulse_go();
        window(25, 127, 127, 0, 1'b0);
        expect_result("t2", 127, 127, 0);

        // ---------------- 3: large negative saturates ----------------
        pulse_go();
        window(25, -128, 127, -5, 1'b0);
        expect_result("t3", exp_neg, exp_neg, 0);

        // ---------------- floor of a small negative, 1x1 ----------------
        pulse_go();
        window(1, -3, 5, -1, 1'b0);
        expect_result("tfloor", exp_floor, exp_floor7, 0);

        // ---------------- 4: overflow with consumer stalled ----------------
        pulse_go();
        for (int i = 1; i <= 4; i++) begin
            window(2, i, 1, 0, 1'b0);
        end
        idle(6);
        check("t4_ovf_after4", 32'(overflow), 0);
        window(2, 5, 1, 0, 1'b0);
        idle(6);
        check("t4_ovf_after5",  32'(overflow), 1);
        check("t4_ovf7_after5", 32'(overflow7), 1);
        window(2, 6, 1, 0, 1'b0);
        idle(6);
        check("t4_head_data", out_data, 2);
        check("t4_head_addr", 32'(out_addr), 0);
        expect_result("t4_r0", 2, 0, 0);
        expect_result("t4_r1", 4, 0, 1);
        expect_result("t4_r2", 6, 0, 2);
        expect_result("t4_r3", 8, 0, 3);
        check("t4_empty", 32'(out_valid), 0);
        check("t4_ovf_sticky", 32'(overflow), 1);

        // ---------------- 5: 1x1 kernel back-to-back ----------------
        pulse_go();
        check("t5_go_clears_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 3, 2, 4);
        end
        idle(6);
        check("t5_ovf", 32'(overflow), 0);
        expect_result("t5_r0", 10, 0, 0);
        expect_result("t5_r1", 10, 0, 1);
        expect_result("t5_r2", 10, 0, 2);
        expect_result("t5_r3", 10, 0, 3);
        check("t5_empty", 32'(out_valid), 0);

        // ---------------- 6: reset mid-window ----------------
        pulse_go();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i == 0, 1'b0, 1'b0, 5, 5, 0);
        end
        rst_n = 1'b0;
        #2;
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_addr",  32'(out_addr), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        window(3, 2, 3, 1, 1'b0);
        expect_result("t6", 19, 0, 0);
        idle(4);
        check("t6_only_one", 32'(out_valid), 0);

        // ---------------- 7: stray beat ignored, first restarts ----------------
        pulse_go();
        step(1'b0, 1'b0, 1'b1, 1'b0, 9, 9, 9);
        step(1'b0, 1'b1, 1'b0, 1'b0, 7, 7, 50);
        step(1'b0, 1'b0, 1'b0, 1'b0, 7, 7, 50);
        window(2, 1, 1, 0, 1'b0);
        expect_result("t7", 2, 0, 0);
        idle(4);
        check("t7_only_one", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
